// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, control encodings and the ID/EX register layout.
package riscv_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ImmI = 2'b00,
    ImmS = 2'b01,
    ImmB = 2'b10,
    ImmJ = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    ResAlu = 2'b00,
    ResMem = 2'b01,
    ResPc4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic        reg_write;
    imm_src_e    imm_src;
    logic        alu_src;
    logic        mem_write;
    result_src_e result_src;
    logic        branch;
    alu_op_e     alu_op;
    logic        jump;
  } ctrl_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } id_ex_t;

endpackage

// File: rtl/decode_cycle_register_file.sv
// Architectural register file: x0 reads as zero, two combinational read ports with
// write-through bypass so a same-cycle WB write is visible to the decoding instruction.
module decode_cycle_register_file #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  // No storage for x0.
  logic [XLEN-1:0] regs_q [1:NUM_REGS-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = '0;
    if (raddr1_i != 5'd0) begin
      if (we_i && (waddr_i == raddr1_i)) begin
        rdata1_o = wdata_i;
      end else begin
        rdata1_o = regs_q[raddr1_i];
      end
    end
  end

  always_comb begin
    rdata2_o = '0;
    if (raddr2_i != 5'd0) begin
      if (we_i && (waddr_i == raddr2_i)) begin
        rdata2_o = wdata_i;
      end else begin
        rdata2_o = regs_q[raddr2_i];
      end
    end
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control/ALU decode, immediate extension, register read and the
// ID/EX pipeline register. Hosts the register file written from WB.
module decode_cycle
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  ctrl_t           ctrl;
  alu_ctrl_e       alu_ctrl;
  logic [XLEN-1:0] imm_ext;
  id_ex_t          id_ex_d, id_ex_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  decode_cycle_register_file #(
    .XLEN    (XLEN),
    .NUM_REGS(NUM_REGS)
  ) u_register_file (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (RegWriteW),
    .waddr_i (RDW),
    .wdata_i (ResultW),
    .raddr1_i(Rs1D),
    .raddr2_i(Rs2D),
    .rdata1_o(rd1),
    .rdata2_o(rd2)
  );

  // Unknown opcodes keep every control bit low, so they travel as bubbles.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OpLoad: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = ResMem;
      end
      OpStore: begin
        ctrl.imm_src   = ImmS;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OpRtype: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = AluOpFunct;
      end
      OpItype: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = AluOpFunct;
      end
      OpBranch: begin
        ctrl.imm_src = ImmB;
        ctrl.branch  = 1'b1;
        ctrl.alu_op  = AluOpSub;
      end
      OpJal: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = ImmJ;
        ctrl.result_src = ResPc4;
        ctrl.jump       = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_ctrl = AluAdd;
    case (ctrl.alu_op)
      AluOpSub: alu_ctrl = AluSub;
      AluOpFunct: begin
        case (funct3)
          // Only R-type with funct7[5] set subtracts; addi never does.
          3'b000:  alu_ctrl = (opcode[5] && InstrD[30]) ? AluSub : AluAdd;
          3'b010:  alu_ctrl = AluSlt;
          3'b110:  alu_ctrl = AluOr;
          3'b111:  alu_ctrl = AluAnd;
          default: alu_ctrl = AluAdd;
        endcase
      end
      default: alu_ctrl = AluAdd;
    endcase
  end

  always_comb begin
    imm_ext = '0;
    case (ctrl.imm_src)
      ImmI: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      ImmS: imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      ImmB: imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      ImmJ: imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  always_comb begin
    id_ex_d             = '0;
    id_ex_d.reg_write   = ctrl.reg_write;
    id_ex_d.mem_write   = ctrl.mem_write;
    id_ex_d.jump        = ctrl.jump;
    id_ex_d.branch      = ctrl.branch;
    id_ex_d.alu_src     = ctrl.alu_src;
    id_ex_d.result_src  = ctrl.result_src;
    id_ex_d.alu_control = alu_ctrl;
    id_ex_d.rd1         = rd1;
    id_ex_d.rd2         = rd2;
    id_ex_d.imm_ext     = imm_ext;
    id_ex_d.rs1         = Rs1D;
    id_ex_d.rs2         = Rs2D;
    id_ex_d.rd          = InstrD[11:7];
    id_ex_d.pc          = PCD;
    id_ex_d.pc_plus4    = PCPlus4D;
  end

  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign RegWriteE   = id_ex_q.reg_write;
  assign MemWriteE   = id_ex_q.mem_write;
  assign JumpE       = id_ex_q.jump;
  assign BranchE     = id_ex_q.branch;
  assign ALUSrcE     = id_ex_q.alu_src;
  assign ResultSrcE  = id_ex_q.result_src;
  assign ALUControlE = id_ex_q.alu_control;
  assign RD1E        = id_ex_q.rd1;
  assign RD2E        = id_ex_q.rd2;
  assign ImmExtE     = id_ex_q.imm_ext;
  assign Rs1E        = id_ex_q.rs1;
  assign Rs2E        = id_ex_q.rs2;
  assign RdE         = id_ex_q.rd;
  assign PCE         = id_ex_q.pc;
  assign PCPlus4E    = id_ex_q.pc_plus4;

endmodule
